dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter REG_OUT, default 1, giving the read latency of the downstream data RAM (1 = registered output, 0 = combinational output).
REQ-002 SHALL have port clk  input  1  sole clock; every register updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  memory-op request from the MEM stage.
REQ-005 SHALL have port req_ready  output  1  request accepted on any cycle where req_valid and req_ready are both high.
REQ-006 SHALL have port req_op  input  3  LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  32  formatted load data, valid only while resp_valid is high.
REQ-011 SHALL have port resp_err  output  1  misaligned access flag, qualified by resp_valid.
REQ-012 SHALL have port stall_req  output  1  pipeline stall request.
REQ-013 SHALL have ports ram_ce, ram_we (1), ram_addr (32), ram_sel (4), ram_wdata (32) as outputs, and ram_rdata (32) as input, connected to the data RAM.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL drive req_ready high in IDLE and RESP, and low in ACCESS.
REQ-016 SHALL, on an aligned acceptance, register op, addr and wdata, then enter ACCESS.
REQ-017 SHALL, on a misaligned acceptance, enter RESP directly with resp_err=1, resp_rdata=0 and no RAM access. Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-018 SHALL go from ACCESS to RESP unconditionally after one cycle.
REQ-019 SHALL, in RESP, go to ACCESS or RESP on a new acceptance (same rules as from IDLE), else go to IDLE.
REQ-020 SHALL assert ram_ce only in ACCESS, with ram_addr = registered address and {ram_addr[1:0]} forced to 0.
REQ-021 SHALL assert ram_we in ACCESS only for store ops.
REQ-022 SHALL drive ram_sel as follows: byte ops = 4'b0001 shifted left by addr[1:0]; half ops = 4'b0011 shifted left by {addr[1],1'b0}; word ops = 4'b1111. Byte lane 0 is data[7:0] (little-endian).
REQ-023 SHALL drive ram_wdata as follows: SB = byte replicated x4; SH = half replicated x2; SW = wdata.
REQ-024 SHALL, for REG_OUT=1, format resp_rdata from ram_rdata during RESP. For REG_OUT=0, it SHALL capture ram_rdata into a data register at the end of ACCESS and format from that register.
REQ-025 SHALL format loads as follows: LB/LBU select the lane at addr[1:0], sign-extended or zero-extended; LH/LHU select lane pair addr[1], sign-extended or zero-extended; LW passes the word through.
REQ-026 SHALL drive resp_rdata = 0 for stores.
REQ-027 SHALL drive resp_err = 0 on aligned responses.
REQ-028 SHALL make accept-to-resp_valid latency exactly 2 cycles for aligned ops and 1 cycle for misaligned ops. Sustained throughput SHALL be one op per 2 cycles.
REQ-029 SHALL drive stall_req = (state==ACCESS) | (req_valid & ~req_ready).
REQ-030 SHALL keep ram_ce and ram_we low in IDLE and RESP, so that the RAM output holds during RESP.

Reset
REQ-031 SHALL, while rst is high, force the following immediately (asynchronously): state=IDLE, ram_ce=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, and all request/data registers to 0.
REQ-032 SHALL, on reset during ACCESS or RESP, discard the in-flight op with no response. A write already strobed before reset is not undone.
REQ-033 SHALL hold req_ready=1 from the first cycle after rst deasserts.

Structure
REQ-034 SHALL place the op encodings, state encoding, and the misalignment and lane-select constants in the shared MIPS definitions package.
REQ-035 SHALL place load lane extraction and extension in one combinational sub-module, dmem_load_align, used once.

Verification
REQ-036 SHALL cover: SW addr 0x10 data 0x11223344 -> ACCESS with ram_we=1, ram_sel=1111, ram_addr=0x10; resp_valid 2 cycles after accept, resp_err=0.
REQ-037 SHALL cover: after that store, LB addr 0x13 -> resp_rdata=0x00000011; LH addr 0x12 -> 0x00001122; LW addr 0x10 -> 0x11223344.
REQ-038 SHALL cover: SB addr 0x21 data 0x000000F0 -> ram_sel=0010, ram_wdata=0xF0F0F0F0; then LB addr 0x21 -> 0xFFFFFFF0 and LBU addr 0x21 -> 0x000000F0.
REQ-039 SHALL cover: LW addr 0x22 -> no ram_ce, resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0; SH addr 0x31 -> no write occurs.
REQ-040 SHALL cover: req_valid held high with 4 loads -> req_ready pattern 1,0,1,0..., one resp per 2 cycles, stall_req high in each ACCESS cycle. Run with both REG_OUT=0 and REG_OUT=1.
REQ-041 SHALL cover: rst asserted in the ACCESS cycle of LW -> outputs zero at once, no resp_valid; the next request after release completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared data-memory definitions: op/state encodings, alignment and lane helpers.
package dmem_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 3;
   localparam int unsigned SEL_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Low address bits that must be zero for each access size
   localparam logic [1:0] HALF_MISALIGN_MASK = 2'b01;
   localparam logic [1:0] WORD_MISALIGN_MASK = 2'b11;

   // Byte-lane enables before shifting to the addressed lane
   localparam logic [SEL_W-1:0] SEL_BYTE = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_HALF = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

   function automatic logic is_store(input mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = |(lo & HALF_MISALIGN_MASK);
         OP_LW, OP_SW:         mis = |(lo & WORD_MISALIGN_MASK);
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [SEL_W-1:0] lane_sel(input mem_op_e op, input logic [1:0] lo);
      logic [SEL_W-1:0] sel;
      case (op)
         OP_LB, OP_LBU, OP_SB: sel = SEL_BYTE << lo;
         OP_LH, OP_LHU, OP_SH: sel = SEL_HALF << {lo[1], 1'b0};
         default:              sel = SEL_WORD;
      endcase
      return sel;
   endfunction

   function automatic logic [XLEN-1:0] store_data(input mem_op_e op, input logic [XLEN-1:0] wdata);
      logic [XLEN-1:0] d;
      case (op)
         OP_SB:   d = {4{wdata[7:0]}};
         OP_SH:   d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword of a RAM word and sign/zero extends it.
module dmem_load_align
   import dmem_ctrl_pkg::*;
(
   input  mem_op_e         op,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] rdata_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Lane select followed by extension; stores yield zero
   always_comb begin
      byte_c  = word[7:0];
      half_c  = addr_lo[1] ? word[31:16] : word[15:0];
      rdata_c = '0;
      case (addr_lo)
         2'd0:    byte_c = word[7:0];
         2'd1:    byte_c = word[15:8];
         2'd2:    byte_c = word[23:16];
         default: byte_c = word[31:24];
      endcase
      case (op)
         OP_LB:   rdata_c = {{24{byte_c[7]}}, byte_c};
         OP_LBU:  rdata_c = {24'd0, byte_c};
         OP_LH:   rdata_c = {{16{half_c[15]}}, half_c};
         OP_LHU:  rdata_c = {16'd0, half_c};
         OP_LW:   rdata_c = word;
         default: rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts MEM-stage ops, drives the data RAM, returns formatted loads.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OP_W-1:0]  req_op,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             resp_valid,
   output logic [XLEN-1:0]  resp_rdata,
   output logic             resp_err,
   output logic             stall_req,
   output logic             ram_ce,
   output logic             ram_we,
   output logic [XLEN-1:0]  ram_addr,
   output logic [SEL_W-1:0] ram_sel,
   output logic [XLEN-1:0]  ram_wdata,
   input  logic [XLEN-1:0]  ram_rdata
);

   state_e          state;
   mem_op_e         op_q;
   logic [1:0]      addr_lo_q;
   logic [XLEN-1:0] data_q;
   mem_op_e         req_op_c;
   logic            accept_c;
   logic [XLEN-1:0] fmt_src_c;
   logic [XLEN-1:0] fmt_c;

   assign req_op_c  = mem_op_e'(req_op);
   assign req_ready = (state != ST_ACCESS);
   assign accept_c  = req_valid & req_ready;
   assign stall_req = (state == ST_ACCESS) | (req_valid & ~req_ready);

   // FSM with registered RAM strobes and response flags; ram_addr/sel/wdata hold between accesses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_q       <= OP_LB;
         addr_lo_q  <= 2'd0;
         data_q     <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         ram_ce     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_sel    <= '0;
         ram_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         ram_ce     <= 1'b0;
         ram_we     <= 1'b0;
         if (state == ST_ACCESS) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            if (REG_OUT == 0) begin
               data_q <= ram_rdata;
            end
         end else if (accept_c) begin
            op_q      <= req_op_c;
            addr_lo_q <= req_addr[1:0];
            if (is_misaligned(req_op_c, req_addr[1:0])) begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
            end else begin
               state     <= ST_ACCESS;
               ram_ce    <= 1'b1;
               ram_we    <= is_store(req_op_c);
               ram_addr  <= {req_addr[XLEN-1:2], 2'b00};
               ram_sel   <= lane_sel(req_op_c, req_addr[1:0]);
               ram_wdata <= store_data(req_op_c, req_wdata);
            end
         end else begin
            state <= ST_IDLE;
         end
      end
   end

   // Registered RAM output is read live in RESP; combinational RAM goes through data_q
   assign fmt_src_c = (REG_OUT != 0) ? ram_rdata : data_q;

   dmem_load_align u_align (
      .op      (op_q),
      .addr_lo (addr_lo_q),
      .word    (fmt_src_c),
      .rdata_c (fmt_c)
   );

   assign resp_rdata = (resp_valid && !resp_err) ? fmt_c : '0;

endmodule
